// File: rtl/mx_tile_sequencer_drain.sv
// mx_tile_sequencer_drain: gates k_len operand pairs per tile into the PE
// wrapper, flushes it, captures the 512-bit tile and drains it in beats.
// Ports: clk_i/rstn; start_i, k_len_i, n_tiles_i set up a job;
//   s_a/s_b valid/ready from streamers, pe_a/pe_b valid/ready to wrapper;
//   send_output_o, pe_out_i, pe_sexp_i wrapper result path;
//   m_data/m_sexp/m_last/m_valid/m_ready drain stream; busy_o, done_o status.
module mx_tile_sequencer_drain #(
   parameter int DATA_W  = 64,
   parameter int OUT_LAT = 2,
   parameter int CNT_W   = 16
) (
   input  logic              clk_i,
   input  logic              rstn,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  k_len_i,
   input  logic [CNT_W-1:0]  n_tiles_i,
   input  logic              s_a_valid_i,
   input  logic              s_b_valid_i,
   output logic              s_a_ready_o,
   output logic              s_b_ready_o,
   output logic              pe_a_valid_o,
   output logic              pe_b_valid_o,
   input  logic              pe_a_ready_i,
   input  logic              pe_b_ready_i,
   output logic              send_output_o,
   input  logic [511:0]      pe_out_i,
   input  logic [7:0]        pe_sexp_i,
   output logic [DATA_W-1:0] m_data_o,
   output logic [7:0]        m_sexp_o,
   output logic              m_last_o,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic              busy_o,
   output logic              done_o
);

   localparam int BEATS = 512 / DATA_W;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0]    LAST_BEAT = BW'(BEATS - 1);
   localparam logic [CNT_W-1:0] LAT_END   = CNT_W'(OUT_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_FLUSH,
      S_WAIT,
      S_DRAIN_LAST
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] k_len_q, k_len_d;
   logic [CNT_W-1:0] n_tiles_q, n_tiles_d;
   logic [CNT_W-1:0] k_cnt_q, k_cnt_d;
   logic [CNT_W-1:0] t_cnt_q, t_cnt_d;
   logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic [511:0]     buf_q, buf_d;
   logic [7:0]       sexp_q, sexp_d;
   logic             drain_q, drain_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic             gate;
   logic             fire;
   logic [CNT_W-1:0] t_next;

   assign gate = (state_q == S_ACCUM) && (k_cnt_q < k_len_q);
   assign fire = gate & s_a_valid_i & s_b_valid_i
               & pe_a_ready_i & pe_b_ready_i;
   assign t_next = t_cnt_q + CNT_W'(1);

   assign s_a_ready_o   = pe_a_ready_i & gate;
   assign s_b_ready_o   = pe_b_ready_i & gate;
   assign pe_a_valid_o  = s_a_valid_i & gate;
   assign pe_b_valid_o  = s_b_valid_i & gate;
   assign send_output_o = (state_q == S_FLUSH);
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_DRAIN_LAST) && !drain_q;

   // The buffer shifts left per accepted beat, so the top slice is
   // always the current beat (MSB-first row order).
   assign m_data_o  = buf_q[511 -: DATA_W];
   assign m_sexp_o  = sexp_q;
   assign m_valid_o = drain_q;
   assign m_last_o  = drain_q && (beat_q == LAST_BEAT);

   always_comb begin
      state_d   = state_q;
      k_len_d   = k_len_q;
      n_tiles_d = n_tiles_q;
      k_cnt_d   = k_cnt_q;
      t_cnt_d   = t_cnt_q;
      lat_cnt_d = lat_cnt_q;
      buf_d     = buf_q;
      sexp_d    = sexp_q;
      drain_d   = drain_q;
      beat_d    = beat_q;

      if (drain_q && m_ready_i) begin
         if (beat_q == LAST_BEAT) begin
            drain_d = 1'b0;
         end else begin
            beat_d = beat_q + BW'(1);
            buf_d  = buf_q << DATA_W;
         end
      end

      if (fire) begin
         k_cnt_d = k_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d   = S_ACCUM;
               k_len_d   = (k_len_i == '0) ? CNT_W'(1) : k_len_i;
               n_tiles_d = (n_tiles_i == '0) ? CNT_W'(1) : n_tiles_i;
               k_cnt_d   = '0;
               t_cnt_d   = '0;
            end
         end
         S_ACCUM: begin
            // Single capture buffer: flush only once the drain is idle.
            if ((k_cnt_q == k_len_q) && !drain_q) begin
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            lat_cnt_d = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            lat_cnt_d = lat_cnt_q + CNT_W'(1);
            if (lat_cnt_q == LAT_END) begin
               buf_d   = pe_out_i;
               sexp_d  = pe_sexp_i;
               drain_d = 1'b1;
               beat_d  = '0;
               t_cnt_d = t_next;
               if (t_next < n_tiles_q) begin
                  state_d = S_ACCUM;
                  k_cnt_d = '0;
               end else begin
                  state_d = S_DRAIN_LAST;
               end
            end
         end
         S_DRAIN_LAST: begin
            if (!drain_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         k_len_q   <= '0;
         n_tiles_q <= '0;
         k_cnt_q   <= '0;
         t_cnt_q   <= '0;
         lat_cnt_q <= '0;
         buf_q     <= '0;
         sexp_q    <= '0;
         drain_q   <= 1'b0;
         beat_q    <= '0;
      end else begin
         state_q   <= state_d;
         k_len_q   <= k_len_d;
         n_tiles_q <= n_tiles_d;
         k_cnt_q   <= k_cnt_d;
         t_cnt_q   <= t_cnt_d;
         lat_cnt_q <= lat_cnt_d;
         buf_q     <= buf_d;
         sexp_q    <= sexp_d;
         drain_q   <= drain_d;
         beat_q    <= beat_d;
      end
   end

endmodule
